// File: rtl/sr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sr_pkg
// Description : Shared types, SR command encodings and the counter-width
//               helper for the SR flop-bank driver.
// Revision    : 1.0 - initial release
// ============================================================================
package sr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_GAP   = 2'd3
    } sr_state_t;

    // Per-flop command as {S, R}; SR_INV is the forbidden combination.
    localparam logic [1:0] SR_HOLD = 2'b00;
    localparam logic [1:0] SR_RST  = 2'b01;
    localparam logic [1:0] SR_SET  = 2'b10;
    localparam logic [1:0] SR_INV  = 2'b11;

    function automatic int sr_cnt_width(input int pulse, input int gap);
        int m;
        m = (pulse > gap) ? pulse : gap;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sr_pulse_timer.sv
`default_nettype none
// ============================================================================
// Module      : sr_pulse_timer
// Description : Loadable down-counter; done is high while the count is zero.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_pulse_timer #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic          done
);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/sr_ff_driver.sv
`default_nettype none
// ============================================================================
// Module      : sr_ff_driver
// Description : Issues fixed-width S/R pulses to an SR flop bank from masked
//               target-value requests, then checks the bank against a shadow.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_ff_driver
    import sr_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int PULSE_CYCLES = 1,
    parameter int GAP_CYCLES   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic [WIDTH-1:0] req_mask,
    output logic [WIDTH-1:0] s_out,
    output logic [WIDTH-1:0] r_out,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] shadow,
    output logic             busy,
    output logic             err,
    output logic [WIDTH-1:0] err_bits,
    input  logic             err_clr
);

    localparam int c_cw = sr_cnt_width(PULSE_CYCLES, GAP_CYCLES);
    // Timer is loaded with N-1 so that done marks the last cycle of the phase.
    localparam logic [c_cw-1:0] c_pulse_load = c_cw'(PULSE_CYCLES - 1);
    localparam logic [c_cw-1:0] c_gap_load   = (GAP_CYCLES > 0) ? c_cw'(GAP_CYCLES - 1) : '0;

    sr_state_t        r_state;
    sr_state_t        w_next_state;
    logic [WIDTH-1:0] r_s_out;
    logic [WIDTH-1:0] r_r_out;
    logic [WIDTH-1:0] r_shadow;
    logic             r_err;
    logic [WIDTH-1:0] r_err_bits;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_mism;
    logic             w_accept;
    logic             w_active;
    logic             w_timer_load;
    logic [c_cw-1:0]  w_timer_val;
    logic             w_timer_en;
    logic             w_timer_done;

    // Each bit resolves to exactly one command, so S and R can never coincide.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic [1:0] w_cmd;
        always_comb begin
            w_cmd = SR_HOLD;
            if (req_mask[gi]) begin
                if (req_data[gi] && !r_shadow[gi]) begin
                    w_cmd = SR_SET;
                end else if (!req_data[gi] && r_shadow[gi]) begin
                    w_cmd = SR_RST;
                end
            end
        end
        assign w_set[gi] = (w_cmd == SR_SET);
        assign w_clr[gi] = (w_cmd == SR_RST);
    end

    assign req_ready = (r_state == ST_IDLE) && !rst;
    assign w_accept  = req_valid && req_ready;
    assign w_active  = |(w_set | w_clr);
    assign w_mism    = (r_state == ST_CHECK) ? (q_in ^ r_shadow) : '0;

    sr_pulse_timer #(
        .CW(c_cw)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_timer_load),
        .load_val (w_timer_val),
        .en       (w_timer_en),
        .done     (w_timer_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_timer_load = 1'b0;
        w_timer_val  = c_pulse_load;
        w_timer_en   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_active) begin
                    w_next_state = ST_DRIVE;
                    w_timer_load = 1'b1;
                end
            end
            ST_DRIVE: begin
                w_timer_en = 1'b1;
                if (w_timer_done) begin
                    w_next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (GAP_CYCLES > 0) begin
                    w_next_state = ST_GAP;
                    w_timer_load = 1'b1;
                    w_timer_val  = c_gap_load;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_GAP: begin
                w_timer_en = 1'b1;
                if (w_timer_done) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_out    <= '0;
            r_r_out    <= '0;
            r_shadow   <= '0;
            r_err      <= 1'b0;
            r_err_bits <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_accept && w_active) begin
                r_s_out  <= w_set;
                r_r_out  <= w_clr;
                r_shadow <= (r_shadow & ~req_mask) | (req_data & req_mask);
            end else if ((r_state == ST_DRIVE) && w_timer_done) begin
                r_s_out <= '0;
                r_r_out <= '0;
            end
            // A fresh mismatch wins over a simultaneous clear.
            r_err_bits <= (err_clr ? '0 : r_err_bits) | w_mism;
            r_err      <= (err_clr ? 1'b0 : r_err) | (|w_mism);
        end
    end

    assign s_out    = r_s_out;
    assign r_out    = r_r_out;
    assign shadow   = r_shadow;
    assign busy     = (r_state != ST_IDLE);
    assign err      = r_err;
    assign err_bits = r_err_bits;

endmodule
`default_nettype wire

// File: tb/tb_sr_ff_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_ff_driver
// Description : Scoreboard bench for sr_ff_driver with three parameter sets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_ff_driver;

    localparam int N = 3;

    typedef struct packed {
        logic [7:0] s;
        logic [7:0] r;
        logic [7:0] sh;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst       [N];
    logic       req_valid [N];
    logic       req_ready [N];
    logic [7:0] req_data  [N];
    logic [7:0] req_mask  [N];
    logic [7:0] s_out     [N];
    logic [7:0] r_out     [N];
    logic [7:0] q         [N];
    logic [7:0] shadow    [N];
    logic       busy      [N];
    logic       err       [N];
    logic [7:0] err_bits  [N];
    logic       err_clr   [N];
    logic [7:0] stuck     [N];
    logic [7:0] msh       [N];

    int   checks = 0;
    int   errors = 0;
    exp_t sb [N][$];

    sr_ff_driver #(.WIDTH(8), .PULSE_CYCLES(1), .GAP_CYCLES(1)) u_dut0 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_data(req_data[0]), .req_mask(req_mask[0]), .s_out(s_out[0]), .r_out(r_out[0]),
        .q_in(q[0]), .shadow(shadow[0]), .busy(busy[0]), .err(err[0]),
        .err_bits(err_bits[0]), .err_clr(err_clr[0]));

    sr_ff_driver #(.WIDTH(8), .PULSE_CYCLES(4), .GAP_CYCLES(3)) u_dut1 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_data(req_data[1]), .req_mask(req_mask[1]), .s_out(s_out[1]), .r_out(r_out[1]),
        .q_in(q[1]), .shadow(shadow[1]), .busy(busy[1]), .err(err[1]),
        .err_bits(err_bits[1]), .err_clr(err_clr[1]));

    sr_ff_driver #(.WIDTH(8), .PULSE_CYCLES(2), .GAP_CYCLES(0)) u_dut2 (
        .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_data(req_data[2]), .req_mask(req_mask[2]), .s_out(s_out[2]), .r_out(r_out[2]),
        .q_in(q[2]), .shadow(shadow[2]), .busy(busy[2]), .err(err[2]),
        .err_bits(err_bits[2]), .err_clr(err_clr[2]));

    function automatic int pc(input int k);
        return (k == 0) ? 1 : (k == 1) ? 4 : 2;
    endfunction

    function automatic int gc(input int k);
        return (k == 0) ? 1 : (k == 1) ? 3 : 0;
    endfunction

    function automatic exp_t mk(input logic [7:0] s, input logic [7:0] r, input logic [7:0] sh);
        exp_t e;
        e.s  = s;
        e.r  = r;
        e.sh = sh;
        return e;
    endfunction

    function automatic exp_t model(input logic [7:0] sh, input logic [7:0] d, input logic [7:0] m);
        return mk(m & d & ~sh, m & ~d & sh, (sh & ~m) | (d & m));
    endfunction

    // Ideal SR flop bank, with optional stuck-at-0 bits.
    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (rst[k]) q[k] <= '0;
            else        q[k] <= ((q[k] | s_out[k]) & ~r_out[k]) & ~stuck[k];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops the expected command on each new pulse, checks its
    // length and the flop state on the CHECK cycle that follows.
    initial begin
        exp_t e;
        bit   act_f [N];
        int   plen  [N];
        for (int k = 0; k < N; k++) begin
            act_f[k] = 1'b0;
            plen[k]  = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                chk("s_and_r_overlap", 32'(s_out[k] & r_out[k]), 32'h0);
                if (rst[k]) begin
                    act_f[k] = 1'b0;
                end else if ((s_out[k] | r_out[k]) != 8'h00) begin
                    if (!act_f[k]) begin
                        if (sb[k].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_pulse: dut=%0d s=%0h r=%0h", k, s_out[k], r_out[k]);
                        end else begin
                            e = sb[k].pop_front();
                            chk("pulse_s", 32'(s_out[k]), 32'(e.s));
                            chk("pulse_r", 32'(r_out[k]), 32'(e.r));
                            chk("pulse_shadow", 32'(shadow[k]), 32'(e.sh));
                        end
                        act_f[k] = 1'b1;
                        plen[k]  = 1;
                    end else begin
                        plen[k]++;
                    end
                end else if (act_f[k]) begin
                    act_f[k] = 1'b0;
                    chk("pulse_len", 32'(plen[k]), 32'(pc(k)));
                    if (stuck[k] == 8'h00) chk("q_vs_shadow", 32'(q[k]), 32'(shadow[k]));
                end
            end
        end
    end

    // Entered and left just after a rising edge; tacc is the cycle in which
    // the handshake completed.
    task automatic send(input int k, input logic [7:0] d, input logic [7:0] m,
                        input bit pulse, input exp_t e, output int tacc);
        bit rdy;
        bit ok;
        req_data[k]  = d;
        req_mask[k]  = m;
        req_valid[k] = 1'b1;
        ok   = 1'b0;
        tacc = -1;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            rdy  = req_ready[k];
            tacc = cyc;
            @(posedge clk);
            #1;
            if (rdy) ok = 1'b1;
        end
        if (ok && pulse) sb[k].push_back(e);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: dut=%0d ready stayed low", k);
        end
        req_valid[k] = 1'b0;
    endtask

    task automatic do_reset(input int k);
        rst[k]       = 1'b1;
        req_valid[k] = 1'b0;
        err_clr[k]   = 1'b0;
        sb[k].delete();
        msh[k] = 8'h00;
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready[k]), 32'h0);
        chk("rst_s_r", 32'({s_out[k], r_out[k]}), 32'h0);
        chk("rst_shadow", 32'(shadow[k]), 32'h0);
        chk("rst_err", 32'({err[k], err_bits[k], busy[k]}), 32'h0);
        @(posedge clk);
        #1;
        rst[k] = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready[k]), 32'h1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t0;
        int   t1;
        int   tprev;
        bit   pprev;
        exp_t e;
        for (int k = 0; k < N; k++) begin
            rst[k]       = 1'b1;
            req_valid[k] = 1'b0;
            req_data[k]  = 8'h00;
            req_mask[k]  = 8'h00;
            err_clr[k]   = 1'b0;
            stuck[k]     = 8'h00;
            msh[k]       = 8'h00;
        end
        @(posedge clk);
        #1;

        // Set A5 from reset
        do_reset(0);
        send(0, 8'hA5, 8'hFF, 1'b1, mk(8'hA5, 8'h00, 8'hA5), t0);
        @(negedge clk);
        chk("t1_busy", 32'(busy[0]), 32'h1);
        @(negedge clk);
        chk("t1_sr_idle_check", 32'({s_out[0], r_out[0]}), 32'h0);
        chk("t1_shadow", 32'(shadow[0]), 32'hA5);
        @(negedge clk);
        chk("t1_ready_T3", 32'(req_ready[0]), 32'h0);
        @(negedge clk);
        chk("t1_ready_T4", 32'(req_ready[0]), 32'h1);
        chk("t1_err", 32'(err[0]), 32'h0);
        @(posedge clk);
        #1;

        // Masked partial update: clear upper bits only
        send(0, 8'h0F, 8'hF0, 1'b1, mk(8'h00, 8'hA0, 8'h05), t0);
        @(negedge clk);
        @(negedge clk);
        chk("t2_shadow", 32'(shadow[0]), 32'h05);
        @(posedge clk);
        #1;

        // Two no-op requests back to back
        send(0, 8'h05, 8'hFF, 1'b0, mk(8'h00, 8'h00, 8'h05), t0);
        send(0, 8'hFF, 8'h00, 1'b0, mk(8'h00, 8'h00, 8'h05), t1);
        chk("t3_noop_spacing", 32'(t1 - t0), 32'h1);
        @(negedge clk);
        chk("t3_busy", 32'(busy[0]), 32'h0);
        chk("t3_shadow", 32'(shadow[0]), 32'h05);
        @(posedge clk);
        #1;

        // Stuck-at-0 on bit 3, then clear
        do_reset(0);
        stuck[0] = 8'h08;
        send(0, 8'h08, 8'h08, 1'b1, mk(8'h08, 8'h00, 8'h08), t0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("t4_err", 32'(err[0]), 32'h1);
        chk("t4_err_bits", 32'(err_bits[0]), 32'h08);
        @(posedge clk);
        #1;
        err_clr[0] = 1'b1;
        @(posedge clk);
        #1;
        err_clr[0] = 1'b0;
        @(negedge clk);
        chk("t4_err_cleared", 32'({err[0], err_bits[0]}), 32'h0);
        chk("t4_shadow_kept", 32'(shadow[0]), 32'h08);
        @(posedge clk);
        #1;

        // err_clr in the CHECK cycle must not hide the new mismatch
        do_reset(0);
        send(0, 8'h08, 8'h08, 1'b1, mk(8'h08, 8'h00, 8'h08), t0);
        @(posedge clk);
        #1;
        err_clr[0] = 1'b1;
        @(posedge clk);
        #1;
        err_clr[0] = 1'b0;
        @(negedge clk);
        chk("clr_vs_check_err", 32'(err[0]), 32'h1);
        chk("clr_vs_check_bits", 32'(err_bits[0]), 32'h08);
        @(posedge clk);
        #1;
        stuck[0] = 8'h00;

        // Reset during the second DRIVE cycle (PULSE_CYCLES=4)
        do_reset(1);
        send(1, 8'hFF, 8'h0F, 1'b1, mk(8'h0F, 8'h00, 8'h0F), t0);
        @(posedge clk);
        #1;
        rst[1] = 1'b1;
        @(negedge clk);
        chk("t5_still_driving", 32'(s_out[1]), 32'h0F);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t5_sr_aborted", 32'({s_out[1], r_out[1]}), 32'h0);
        chk("t5_shadow", 32'(shadow[1]), 32'h0);
        chk("t5_ready_in_rst", 32'(req_ready[1]), 32'h0);
        @(posedge clk);
        #1;
        rst[1] = 1'b0;
        @(negedge clk);
        chk("t5_ready_after", 32'(req_ready[1]), 32'h1);
        repeat (8) @(negedge clk);
        chk("t5_no_err", 32'({err[1], err_bits[1], busy[1]}), 32'h0);
        @(posedge clk);
        #1;
        msh[1] = 8'h00;

        // Back-to-back random requests, valid held high
        do_reset(2);
        for (int k = 1; k < N; k++) begin
            tprev = 0;
            pprev = 1'b0;
            for (int i = 0; i < 24; i++) begin
                logic [7:0] d;
                logic [7:0] m;
                bit         p;
                d = 8'($urandom);
                m = (i % 5 == 4) ? 8'h00 : 8'($urandom);
                e = model(msh[k], d, m);
                p = ((e.s | e.r) != 8'h00);
                send(k, d, m, p, e, t0);
                if (i > 0) chk("t6_accept_spacing", 32'(t0 - tprev),
                               pprev ? 32'(pc(k) + 2 + gc(k)) : 32'h1);
                msh[k] = e.sh;
                tprev  = t0;
                pprev  = p;
            end
            repeat (12) @(negedge clk);
            chk("t6_shadow", 32'(shadow[k]), 32'(msh[k]));
            chk("t6_no_err", 32'(err[k]), 32'h0);
            @(posedge clk);
            #1;
        end

        repeat (4) @(negedge clk);
        for (int k = 0; k < N; k++) chk("scoreboard_drained", 32'(sb[k].size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sr_ff_driver.md
# sr_ff_driver

Command generator for a bank of `WIDTH` SR flip-flops. It accepts target-value requests over a valid/ready handshake and keeps a shadow copy of the bank state. For each request it issues S/R pulses of fixed width, never driving S and R together, then reads the flop outputs back and flags any mismatch. It is the control side of the SR flop bank: it generates the S, R inputs that the flops consume.

## Interface
Parameters:
- `WIDTH`, 8: number of SR flops driven.
- `PULSE_CYCLES`, 1: cycles S/R are held asserted per command; must be ≥1.
- `GAP_CYCLES`, 1: idle (S=R=0) cycles after readback before the next request is accepted; may be 0.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_data`  in  WIDTH  target value per bit.
- `req_mask`  in  WIDTH  1 = bit participates; 0 = bit untouched.
- `s_out`  out  WIDTH  set inputs to the flop bank.
- `r_out`  out  WIDTH  reset inputs to the flop bank.
- `q_in`  in  WIDTH  Q outputs of the flop bank.
- `shadow`  out  WIDTH  expected bank state.
- `busy`  out  1  high in any state other than IDLE.
- `err`  out  1  sticky readback-mismatch flag.
- `err_bits`  out  WIDTH  sticky per-bit mismatch.
- `err_clr`  in  1  clears `err`/`err_bits`.

## Operation
- FSM states: IDLE → DRIVE → CHECK → GAP → IDLE. GAP is skipped when `GAP_CYCLES`=0.
- `req_ready` = (state==IDLE) && !rst.
- On acceptance, with shadow value `sh`:
  - `set = mask & data & ~sh`
  - `clr = mask & ~data & sh`
- If `set|clr`==0, the request is a no-op: the FSM stays in IDLE, no pulse is issued, and `req_ready` stays 1.
- Otherwise the FSM enters DRIVE:
  - `s_out=set`, `r_out=clr` are registered and held `PULSE_CYCLES` cycles.
  - `shadow <= (sh & ~mask) | (data & mask)` on the acceptance edge.
- In CHECK (one cycle, S=R=0):
  - `err_bits <= err_bits | (q_in ^ shadow)`
  - `err <= err | (|(q_in ^ shadow))`
- GAP counts `GAP_CYCLES` cycles with S=R=0, then returns to IDLE.
- Invariant: `s_out & r_out` == 0 in every cycle. The 2'b11 (invalid) command is never generated.
- `err_clr` clears the sticky error state. If `err_clr` coincides with a new mismatch in CHECK, the new mismatch bits are set; they are not cleared.
- Unmasked bits never receive S or R.

## Timing
- Reset values, applied at the edge where `rst`=1:
  - `s_out=0`, `r_out=0`, `shadow=0` (matches flop reset value 0)
  - `err=0`, `err_bits=0`, `busy=0`
  - FSM in IDLE, counters 0
  - `req_ready=0` while `rst` is high and 1 on the first cycle after it drops.
- Reset mid-operation (any state) aborts the command. S/R are 0 from the next cycle, and no CHECK is performed.
- For a request accepted in cycle T:
  - S/R are driven in cycles T+1 … T+PULSE_CYCLES.
  - CHECK is at T+PULSE_CYCLES+1.
  - `req_ready` is 1 again at T+PULSE_CYCLES+2+GAP_CYCLES.
- No-op request at T: the next request can be accepted at T+1.
- `req_valid` held high while busy: the request is accepted on the first IDLE cycle. `req_data`/`req_mask` are sampled only at the acceptance edge.

## Structure
- Shared package `sr_pkg` holds:
  - FSM state enum (IDLE, DRIVE, CHECK, GAP).
  - Command encodings: SR_HOLD=2'b00, SR_RST=2'b01, SR_SET=2'b10, SR_INV=2'b11 (never driven).
  - Counter width function `$clog2(max(PULSE_CYCLES,GAP_CYCLES)+1)`.
- One sub-module, `sr_pulse_timer`: a loadable down-counter with `done` output, shared by DRIVE and GAP.
- Everything else lives in `sr_ff_driver`.

## Test plan
1. Reset, then request data=8'hA5 mask=8'hFF at T (defaults) → at T+1 `s_out`=A5, `r_out`=00; at T+2 S=R=0 and `shadow`=A5; `req_ready`=1 at T+4; `err`=0 with an ideal flop model.
2. After 1, request data=8'h0F mask=8'hF0 → `s_out`=00, `r_out`=A0 for one cycle; `shadow`=05.
3. Request data equal to `shadow` with mask=FF → no S/R activity, `busy` stays 0, and a second request is accepted in the next cycle.
4. Flop model bit 3 stuck at 0; request data=08 mask=08 → at CHECK `err`=1 and `err_bits`=08; one cycle of `err_clr` → both 0; `shadow` remains 08.
5. `PULSE_CYCLES`=4: assert `rst` during the 2nd DRIVE cycle → next cycle `s_out`=`r_out`=0, `shadow`=0, no error logged; `req_ready`=1 one cycle after `rst` drops.
6. Random back-to-back requests with `req_valid` held high, `GAP_CYCLES`=0 and 3 → accepts happen only in IDLE; S/R are never both 1 on any bit; flop model Q always equals `shadow` at CHECK.
